instruction_compress_packer: RTL and testbench

INSTRUCTION_COMPRESS_PACKER -- requirements
Module: instruction_compress_packer

---
 rtl/instruction_compress_packer.sv | 179 +++++++++++++++++
 tb/tb_instruction_compress_packer.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_compress_packer.sv
// Instruction compress packer: converts eligible RV32I instructions into
// 16-bit RVC parcels and packs the resulting parcel stream into 32-bit
// fetch words, lower halfword first.
module instruction_compress_packer #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instr,
    input  logic                   flush,
    output logic                   flush_done,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_word,
    output logic [COUNT_WIDTH-1:0] compressed_count
);

    typedef enum logic {EMPTY, HALF} state_t;

    // Returns {is_16bit, parcel}; parcel is only meaningful when is_16bit is set.
    function automatic logic [16:0] compress(input logic [31:0] ins);
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] imm_i, imm_s;
        logic [20:1] imm_j;
        logic        is_addi, is_add, is_alu, is_lw, is_sw, is_jal, is_jalr;
        logic        i_small, j_small, rdp, rs1p, rs2p;
        logic [1:0]  alu_f2;
        logic [16:0] res;
        opc   = ins[6:0];
        f3    = ins[14:12];
        f7    = ins[31:25];
        rd    = ins[11:7];
        rs1   = ins[19:15];
        rs2   = ins[24:20];
        imm_i = ins[31:20];
        imm_s = {ins[31:25], ins[11:7]};
        imm_j = {ins[31], ins[19:12], ins[20], ins[30:21]};
        is_addi = (opc == 7'b0010011) && (f3 == 3'b000);
        is_add  = (opc == 7'b0110011) && (f3 == 3'b000) && (f7 == 7'b0000000);
        is_alu  = (opc == 7'b0110011) &&
                  (((f7 == 7'b0100000) && (f3 == 3'b000)) ||
                   ((f7 == 7'b0000000) && ((f3 == 3'b100) || (f3 == 3'b110) || (f3 == 3'b111))));
        is_lw   = (opc == 7'b0000011) && (f3 == 3'b010);
        is_sw   = (opc == 7'b0100011) && (f3 == 3'b010);
        is_jal  = (opc == 7'b1101111);
        is_jalr = (opc == 7'b1100111) && (f3 == 3'b000);
        // Immediate fits the 6-bit signed field / 12-bit signed jump field.
        i_small = (imm_i[11:5] == {7{imm_i[5]}});
        j_small = (imm_j[20:11] == {10{imm_j[11]}});
        // Registers reachable through the 3-bit compressed register fields.
        rdp  = (rd[4:3]  == 2'b01);
        rs1p = (rs1[4:3] == 2'b01);
        rs2p = (rs2[4:3] == 2'b01);
        case (f3)
            3'b100:  alu_f2 = 2'b01;
            3'b110:  alu_f2 = 2'b10;
            3'b111:  alu_f2 = 2'b11;
            default: alu_f2 = 2'b00;
        endcase
        res = 17'd0;
        if (ins[1:0] != 2'b11)
            res = {1'b1, ins[15:0]};
        else if (is_addi && rd == 5'd0 && rs1 == 5'd0 && imm_i == 12'd0)
            res = {1'b1, 16'h0001};
        else if (is_addi && rd == rs1 && rd != 5'd0 && imm_i != 12'd0 && i_small)
            res = {1'b1, 3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
        else if (is_addi && rd != 5'd0 && rs1 == 5'd0 && i_small)
            res = {1'b1, 3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
        else if (is_add && rd != 5'd0 && rs1 == 5'd0 && rs2 != 5'd0)
            res = {1'b1, 4'b1000, rd, rs2, 2'b10};
        else if (is_add && rd == rs1 && rd != 5'd0 && rs2 != 5'd0)
            res = {1'b1, 4'b1001, rd, rs2, 2'b10};
        else if (is_alu && rd == rs1 && rdp && rs2p)
            res = {1'b1, 6'b100011, rd[2:0], alu_f2, rs2[2:0], 2'b01};
        else if (is_lw && rdp && rs1p && imm_i[1:0] == 2'b00 && imm_i[11:7] == 5'd0)
            res = {1'b1, 3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
        else if (is_lw && rd != 5'd0 && rs1 == 5'd2 && imm_i[1:0] == 2'b00 && imm_i[11:8] == 4'd0)
            res = {1'b1, 3'b010, imm_i[5], rd, imm_i[4:2], imm_i[7:6], 2'b10};
        else if (is_sw && rs1p && rs2p && imm_s[1:0] == 2'b00 && imm_s[11:7] == 5'd0)
            res = {1'b1, 3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
        else if (is_sw && rs1 == 5'd2 && imm_s[1:0] == 2'b00 && imm_s[11:8] == 4'd0)
            res = {1'b1, 3'b110, imm_s[5:2], imm_s[7:6], rs2, 2'b10};
        else if (is_jal && (rd == 5'd0 || rd == 5'd1) && j_small)
            res = {1'b1, ~rd[0], 2'b01, imm_j[11], imm_j[4], imm_j[9:8], imm_j[10],
                   imm_j[6], imm_j[7], imm_j[3:1], imm_j[5], 2'b01};
        else if (is_jalr && imm_i == 12'd0 && rs1 != 5'd0 && (rd == 5'd0 || rd == 5'd1))
            res = {1'b1, 3'b100, rd[0], rs1, 5'd0, 2'b10};
        return res;
    endfunction

    state_t                 state_reg, state_next;
    logic [15:0]            hold_reg, hold_next;
    logic                   out_valid_reg, out_valid_next;
    logic [31:0]            out_word_reg, out_word_next;
    logic [COUNT_WIDTH-1:0] count_reg, count_next;

    logic [16:0] comp;
    logic        is16;
    logic [15:0] parcel;
    logic        accept, xfer, out_free;

    assign comp     = compress(in_instr);
    assign is16     = comp[16];
    assign parcel   = comp[15:0];
    assign out_free = !out_valid_reg || out_ready;
    assign in_ready = !flush && out_free;
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid_reg && out_ready;

    assign out_valid        = out_valid_reg;
    assign out_word         = out_word_reg;
    assign compressed_count = count_reg;
    assign flush_done       = (state_reg == EMPTY) && !out_valid_reg;

    // Next-state: accept and flush are exclusive because flush blocks in_ready.
    always_comb begin
        state_next     = state_reg;
        hold_next      = hold_reg;
        out_valid_next = out_valid_reg;
        out_word_next  = out_word_reg;
        count_next     = count_reg;
        if (xfer)
            out_valid_next = 1'b0;
        if (accept) begin
            if (is16 && count_reg != {COUNT_WIDTH{1'b1}})
                count_next = count_reg + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
            case (state_reg)
                EMPTY: begin
                    if (is16) begin
                        hold_next  = parcel;
                        state_next = HALF;
                    end else begin
                        out_word_next  = in_instr;
                        out_valid_next = 1'b1;
                    end
                end
                HALF: begin
                    out_valid_next = 1'b1;
                    if (is16) begin
                        out_word_next = {parcel, hold_reg};
                        state_next    = EMPTY;
                    end else begin
                        out_word_next = {in_instr[15:0], hold_reg};
                        hold_next     = in_instr[31:16];
                    end
                end
                default: state_next = EMPTY;
            endcase
        end else if (flush && state_reg == HALF && out_free) begin
            // Pad the pending halfword with a C.NOP to complete the word.
            out_word_next  = {16'h0001, hold_reg};
            out_valid_next = 1'b1;
            state_next     = EMPTY;
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= EMPTY;
            hold_reg      <= 16'd0;
            out_valid_reg <= 1'b0;
            out_word_reg  <= 32'd0;
            count_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            hold_reg      <= hold_next;
            out_valid_reg <= out_valid_next;
            out_word_reg  <= out_word_next;
            count_reg     <= count_next;
        end
    end

endmodule

// File: tb/tb_instruction_compress_packer.sv
// Testbench for instruction_compress_packer: directed steps plus a random
// instruction stream; output words are expanded and compared in order.
module tb_instruction_compress_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_ready;
    logic        in_ready, flush_done, out_valid;
    logic [31:0] out_word;
    logic [15:0] compressed_count;
    logic        in_ready_s, flush_done_s, out_valid_s;
    logic [31:0] out_word_s;
    logic [2:0]  count_s;

    typedef struct packed {
        logic [31:0] instr;
        logic        c16;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] hq[$];
    logic [31:0] wq[$];
    int          exp_cnt = 0;
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          rand_bp = 1'b0;

    instruction_compress_packer #(.COUNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .flush(flush), .flush_done(flush_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .compressed_count(compressed_count)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation.
    instruction_compress_packer #(.COUNT_WIDTH(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_instr(in_instr), .flush(flush), .flush_done(flush_done_s),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_word(out_word_s),
        .compressed_count(count_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        assert (got === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, expv);
        end
    endtask

    // Reference RVC expander for the parcel forms the packer may emit.
    function automatic logic [31:0] expand16(input logic [15:0] h);
        logic [11:0] i6, uw;
        logic [4:0]  r1, r2, rp1, rp2;
        logic [20:0] jo;
        logic [31:0] r;
        r   = 32'hDEADBEEF;
        i6  = {{6{h[12]}}, h[12], h[6:2]};
        r1  = h[11:7];
        r2  = h[6:2];
        rp1 = {2'b01, h[9:7]};
        rp2 = {2'b01, h[4:2]};
        case ({h[1:0], h[15:13]})
            5'b01_000: r = {i6, r1, 3'b000, r1, 7'b0010011};
            5'b01_010: r = {i6, 5'd0, 3'b000, r1, 7'b0010011};
            5'b01_100: if (h[12:10] == 3'b011) begin
                case (h[6:5])
                    2'b00: r = {7'b0100000, rp2, rp1, 3'b000, rp1, 7'b0110011};
                    2'b01: r = {7'b0000000, rp2, rp1, 3'b100, rp1, 7'b0110011};
                    2'b10: r = {7'b0000000, rp2, rp1, 3'b110, rp1, 7'b0110011};
                    default: r = {7'b0000000, rp2, rp1, 3'b111, rp1, 7'b0110011};
                endcase
            end
            5'b01_001, 5'b01_101: begin
                jo = {{9{h[12]}}, h[12], h[8], h[10:9], h[6], h[7], h[2], h[11], h[5:3], 1'b0};
                r  = {jo[20], jo[10:1], jo[11], jo[19:12], (h[15] ? 5'd0 : 5'd1), 7'b1101111};
            end
            5'b00_010: begin
                uw = {5'b0, h[5], h[12:10], h[6], 2'b00};
                r  = {uw, rp1, 3'b010, rp2, 7'b0000011};
            end
            5'b00_110: begin
                uw = {5'b0, h[5], h[12:10], h[6], 2'b00};
                r  = {uw[11:5], rp2, rp1, 3'b010, uw[4:0], 7'b0100011};
            end
            5'b10_010: begin
                uw = {4'b0, h[3:2], h[12], h[6:4], 2'b00};
                r  = {uw, 5'd2, 3'b010, r1, 7'b0000011};
            end
            5'b10_110: begin
                uw = {4'b0, h[8:7], h[12:9], 2'b00};
                r  = {uw[11:5], r2, 5'd2, 3'b010, uw[4:0], 7'b0100011};
            end
            5'b10_100: begin
                if (!h[12])
                    r = (r2 == 5'd0) ? {12'b0, r1, 3'b000, 5'd0, 7'b1100111}
                                     : {7'b0, r2, 5'd0, 3'b000, r1, 7'b0110011};
                else
                    r = (r2 == 5'd0) ? {12'b0, r1, 3'b000, 5'd1, 7'b1100111}
                                     : {7'b0, r2, r1, 3'b000, r1, 7'b0110011};
            end
            default: ;
        endcase
        return r;
    endfunction

    // Output scoreboard: split each transferred word into parcels and match
    // them, in order, against the accepted instructions.
    logic [15:0] mh;
    logic [31:0] mfull;
    exp_t        me;
    bit          mdone;
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            $display("[TB] out word %h", out_word);
            if (wq.size() > 0)
                check("word", out_word, wq.pop_front());
            hq.push_back(out_word[15:0]);
            hq.push_back(out_word[31:16]);
            mdone = 1'b0;
            while (!mdone && hq.size() > 0) begin
                if (hq[0][1:0] != 2'b11) begin
                    mh = hq.pop_front();
                    if (exp_q.size() == 0) begin
                        check("pad_nop", {16'h0, mh}, 32'h0000_0001);
                    end else begin
                        me = exp_q.pop_front();
                        check("size16", 32'(me.c16), 32'd1);
                        check("expand16", expand16(mh), me.instr);
                    end
                end else if (hq.size() >= 2) begin
                    mfull = {hq[1], hq[0]};
                    void'(hq.pop_front());
                    void'(hq.pop_front());
                    if (exp_q.size() == 0) begin
                        check("extra32", mfull, 32'h0);
                    end else begin
                        me = exp_q.pop_front();
                        check("size32", 32'(me.c16), 32'd0);
                        check("instr32", mfull, me.instr);
                    end
                end else begin
                    mdone = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] expi, input logic c16);
        bit   ok;
        exp_t e;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_instr = ins;
        for (int k = 0; k < 100 && !ok; k++) begin
            if (rand_bp) out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (in_ready) begin
                ok      = 1'b1;
                e.instr = expi;
                e.c16   = c16;
                exp_q.push_back(e);
                if (c16) exp_cnt++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) check("accept_timeout", 32'(ok), 32'd1);
    endtask

    task automatic do_flush();
        bit ok;
        ok    = 1'b0;
        flush = 1'b1;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (flush_done) ok = 1'b1;
        end
        check("flush_drain", 32'(ok), 32'd1);
        tick();
        flush = 1'b0;
    endtask

    function automatic logic [4:0] rreg();
        int s;
        s = $urandom_range(0, 19);
        if (s < 8) return 5'($urandom_range(8, 15));
        if (s < 11) return 5'd0;
        if (s < 13) return 5'd2;
        if (s < 15) return 5'd1;
        return 5'($urandom_range(0, 31));
    endfunction

    function automatic bit prime(input logic [4:0] r);
        return r >= 5'd8 && r <= 5'd15;
    endfunction

    function automatic bit small6(input logic [11:0] v);
        int s;
        s = int'($signed(v));
        return s >= -32 && s <= 31;
    endfunction

    function automatic logic [11:0] rimm();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 1) == 0) return 12'($urandom_range(0, 63)) - 12'd32;
        return r[11:0];
    endfunction

    function automatic logic [11:0] roff();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 1) == 0) return 12'($urandom_range(0, 70) * 4);
        return r[11:0];
    endfunction

    // Random legal RV32I instruction, with the expected compressibility
    // decided directly from the chosen fields.
    task automatic gen(output logic [31:0] ins, output logic c16);
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] imm;
        logic [20:0] j;
        logic [31:0] r;
        int          o, sj, k;
        rd  = rreg();
        rs1 = rreg();
        rs2 = rreg();
        r   = $urandom;
        case ($urandom_range(0, 8))
            0: begin
                if ($urandom_range(0, 2) == 0) rs1 = rd;
                else if ($urandom_range(0, 1) == 0) rs1 = 5'd0;
                imm = ($urandom_range(0, 5) == 0) ? 12'd0 : rimm();
                ins = {imm, rs1, 3'b000, rd, 7'b0010011};
                c16 = (rd == 0 && rs1 == 0 && imm == 0) ||
                      (rd != 0 && rd == rs1 && imm != 0 && small6(imm)) ||
                      (rd != 0 && rs1 == 0 && small6(imm));
            end
            1: begin
                if ($urandom_range(0, 2) == 0) rs1 = rd;
                else if ($urandom_range(0, 1) == 0) rs1 = 5'd0;
                ins = {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
                c16 = (rd != 0 && rs1 == 0 && rs2 != 0) || (rd != 0 && rd == rs1 && rs2 != 0);
            end
            2: begin
                if ($urandom_range(0, 2) != 0) rs1 = rd;
                k = $urandom_range(0, 3);
                case (k)
                    0: ins = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
                    1: ins = {7'b0000000, rs2, rs1, 3'b100, rd, 7'b0110011};
                    2: ins = {7'b0000000, rs2, rs1, 3'b110, rd, 7'b0110011};
                    default: ins = {7'b0000000, rs2, rs1, 3'b111, rd, 7'b0110011};
                endcase
                c16 = (rd == rs1) && prime(rd) && prime(rs2);
            end
            3: begin
                if ($urandom_range(0, 2) == 0) rs1 = 5'd2;
                imm = roff();
                ins = {imm, rs1, 3'b010, rd, 7'b0000011};
                c16 = (prime(rd) && prime(rs1) && imm[1:0] == 0 && imm <= 12'd124) ||
                      (rd != 0 && rs1 == 2 && imm[1:0] == 0 && imm <= 12'd252);
            end
            4: begin
                if ($urandom_range(0, 2) == 0) rs1 = 5'd2;
                imm = roff();
                ins = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
                c16 = (prime(rs1) && prime(rs2) && imm[1:0] == 0 && imm <= 12'd124) ||
                      (rs1 == 2 && imm[1:0] == 0 && imm <= 12'd252);
            end
            5: begin
                k = $urandom_range(0, 3);
                if (k == 0) rd = 5'd0;
                else if (k == 1) rd = 5'd1;
                if ($urandom_range(0, 1) == 0) begin
                    o = (int'($urandom_range(0, 2100)) - 1050) * 2;
                    j = 21'(o);
                end else begin
                    j = {r[20:1], 1'b0};
                end
                sj  = int'($signed(j));
                ins = {j[20], j[10:1], j[11], j[19:12], rd, 7'b1101111};
                c16 = (rd == 0 || rd == 1) && sj >= -2048 && sj <= 2046;
            end
            6: begin
                k = $urandom_range(0, 3);
                if (k == 0) rd = 5'd0;
                else if (k == 1) rd = 5'd1;
                imm = ($urandom_range(0, 1) == 0) ? 12'd0 : r[11:0];
                ins = {imm, rs1, 3'b000, rd, 7'b1100111};
                c16 = (imm == 0) && (rs1 != 0) && (rd == 0 || rd == 1);
            end
            default: begin
                ins = {r[31:12], rd, 7'b0110111};
                c16 = 1'b0;
            end
        endcase
    endtask

    logic [31:0] gi_ins;
    logic        gi_c16;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        flush     = 1'b0;
        out_ready = 1'b1;

        // Reset state while rst_n is held low.
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_flush_done", 32'(flush_done), 32'd1);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_flush_done", 32'(flush_done), 32'd1);
        check("idle_count", 32'(compressed_count), 32'd0);

        // Two C.ADDI parcels packed into one word.
        wq.push_back(32'h0505_0505);
        send(32'h0015_0513, 32'h0015_0513, 1'b1);
        send(32'h0015_0513, 32'h0015_0513, 1'b1);
        check("addi_pair_valid", 32'(out_valid), 32'd1);
        check("addi_pair_word", out_word, 32'h0505_0505);
        check("addi_pair_count", 32'(compressed_count), 32'd2);
        check("sat_count_2", 32'(count_s), 32'd2);

        // Uncompressible LUI from EMPTY, accepted while the previous word drains.
        wq.push_back(32'h1234_52B7);
        send(32'h1234_52B7, 32'h1234_52B7, 1'b0);
        check("lui_valid", 32'(out_valid), 32'd1);
        check("lui_word", out_word, 32'h1234_52B7);
        check("lui_count", 32'(compressed_count), 32'd2);

        // C.NOP then LUI straddling words, then flush padding.
        wq.push_back(32'h52B7_0001);
        wq.push_back(32'h0001_1234);
        send(32'h0000_0013, 32'h0000_0013, 1'b1);
        check("half_flush_done", 32'(flush_done), 32'd0);
        send(32'h1234_52B7, 32'h1234_52B7, 1'b0);
        check("straddle_word", out_word, 32'h52B7_0001);
        check("straddle_half", 32'(flush_done), 32'd0);
        flush = 1'b1;
        tick();
        check("flush_in_ready", 32'(in_ready), 32'd0);
        check("flush_valid", 32'(out_valid), 32'd1);
        check("flush_word", out_word, 32'h0001_1234);
        tick();
        check("flush_done_after", 32'(flush_done), 32'd1);
        flush = 1'b0;

        // Backpressure: word held stable, then no bubble on release.
        out_ready = 1'b0;
        wq.push_back(32'hABCD_E0B7);
        wq.push_back(32'h1357_9137);
        send(32'hABCD_E0B7, 32'hABCD_E0B7, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_word", out_word, 32'hABCD_E0B7);
            tick();
        end
        in_valid  = 1'b1;
        in_instr  = 32'h1357_9137;
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", 32'(in_ready), 32'd1);
        exp_q.push_back({32'h1357_9137, 1'b0});
        tick();
        in_valid = 1'b0;
        check("release_valid", 32'(out_valid), 32'd1);
        check("release_word", out_word, 32'h1357_9137);

        // Raw RVC parcels pass through, upper input bits ignored.
        wq.push_back(32'h4501_4501);
        send(32'hFFFF_4501, 32'h0000_0513, 1'b1);
        send(32'hFFFF_4501, 32'h0000_0513, 1'b1);
        check("rvc_word", out_word, 32'h4501_4501);
        check("rvc_count", 32'(compressed_count), 32'(exp_cnt));
        tick();

        // Asynchronous reset with a pending half and an unconsumed word.
        out_ready = 1'b0;
        send(32'h0015_0513, 32'h0015_0513, 1'b1);
        send(32'h1234_52B7, 32'h1234_52B7, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_word", out_word, 32'h0);
        check("arst_flush_done", 32'(flush_done), 32'd1);
        check("arst_count", 32'(compressed_count), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        hq.delete();
        wq.delete();
        exp_cnt = 0;
        tick();
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        check("post_rst_valid", 32'(out_valid), 32'd0);

        // Random stream with random backpressure and idle gaps.
        rand_bp = 1'b1;
        for (int n = 0; n < 400; n++) begin
            gen(gi_ins, gi_c16);
            send(gi_ins, gi_ins, gi_c16);
            if ($urandom_range(0, 3) == 0) begin
                out_ready = ($urandom_range(0, 1) != 0);
                tick();
            end
        end
        rand_bp   = 1'b0;
        out_ready = 1'b1;
        do_flush();
        tick();
        check("drain_exp_empty", 32'(exp_q.size()), 32'd0);
        check("drain_parcels_empty", 32'(hq.size()), 32'd0);
        check("final_count", 32'(compressed_count), 32'(exp_cnt));
        check("sat_count", 32'(count_s), (exp_cnt > 7) ? 32'd7 : 32'(exp_cnt));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
